snake_direction_input: RTL and testbench

- Input-side counterpart to the VGA output path of the Snake top level.
- Turns the five raw push-buttons into clean, one-cycle press events.
- Converts direction presses into a small queue of legal heading changes, consumed one per game step.
- Tracks a pause toggle driven by the centre button; the game-logic block reads Heading and Paused.

---
 rtl/snake_direction_input_pkg.sv | 32 +++
 rtl/snake_direction_input_button_debouncer.sv | 75 +++++++
 rtl/snake_direction_input.sv | 128 ++++++++++++
 tb/tb_snake_direction_input.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_direction_input_pkg.sv
// Shared constants and helpers for the Snake button/direction input path.
// Direction encoding is also used by the game-logic block.
package snake_direction_input_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_e;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

   localparam int BTN_UP     = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 3;
   localparam int BTN_CENTER = 4;
   localparam int NUM_BTN    = 5;

   // Opposite heading: flipping bit 1 swaps UP<->DOWN and RIGHT<->LEFT.
   function automatic dir_e dir_reverse(input dir_e d);
      return dir_e'(d ^ 2'd2);
   endfunction

   function automatic logic [1:0] ptr_inc(input logic [1:0] ptr, input int depth);
      if (int'(ptr) == depth - 1)
         return 2'd0;
      return ptr + 2'd1;
   endfunction

endpackage

// File: rtl/snake_direction_input_button_debouncer.sv
// One button: 2-flop synchronizer, debounce counter and press pulse.
// Defining SNAKE_DEBOUNCE_BYPASS_EN removes the counter (stable follows synced).
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_i,
   output logic press_o
);

   logic sync1_q, sync2_q;
   logic stable_q, stable_d;
   logic press_q, press_d;

`ifdef SNAKE_DEBOUNCE_BYPASS_EN
   always_comb begin
      stable_d = sync2_q;
      press_d  = sync2_q & ~stable_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= button_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end
`else
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while synced disagrees with stable; any agreement restarts it.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            press_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= button_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end
`endif

   assign press_o = press_q;

endmodule

// File: rtl/snake_direction_input.sv
// Snake input path: debounced buttons, direction queue, heading and pause state.
// Optional SNAKE_DEBOUNCE_BYPASS_EN shortens debouncing for fast simulation.
module snake_direction_input
   import snake_direction_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 18,
   parameter int QUEUE_DEPTH     = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       ButtonLeft,
   input  logic       ButtonRight,
   input  logic       ButtonUp,
   input  logic       ButtonDown,
   input  logic       ButtonCenter,
   input  logic       StepTick,
   output logic [1:0] Heading,
   output logic       Paused,
   output logic [2:0] QueueCount,
   output logic       DirAccepted,
   output logic       DirDropped
);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;

   assign btn_raw = {ButtonCenter, ButtonLeft, ButtonDown, ButtonRight, ButtonUp};

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clk_i   (Clock),
         .rst_i   (Reset),
         .button_i(btn_raw[b]),
         .press_o (press[b])
      );
   end

   dir_e       q_mem [4];
   logic [1:0] head_q, head_d;
   logic [1:0] tail_q, tail_d;
   logic [1:0] last_idx;
   logic [2:0] count_q, count_d;
   dir_e       heading_q, heading_d;
   logic       paused_q, paused_d;
   logic       acc_q, acc_d;
   logic       drop_q, drop_d;

   logic       ev_valid;
   dir_e       ev_dir;
   dir_e       ref_dir;
   logic       full;
   logic       pop;
   logic       push;

   // Only the highest-priority direction is looked at; the rest vanish silently.
   always_comb begin
      ev_valid = 1'b1;
      ev_dir   = DIR_UP;
      if (press[BTN_UP])
         ev_dir = DIR_UP;
      else if (press[BTN_RIGHT])
         ev_dir = DIR_RIGHT;
      else if (press[BTN_DOWN])
         ev_dir = DIR_DOWN;
      else if (press[BTN_LEFT])
         ev_dir = DIR_LEFT;
      else
         ev_valid = 1'b0;
   end

   assign last_idx = (tail_q == 2'd0) ? 2'(QUEUE_DEPTH - 1) : tail_q - 2'd1;
   assign ref_dir  = (count_q != 3'd0) ? q_mem[last_idx] : heading_q;
   assign full     = (count_q == 3'(QUEUE_DEPTH));
   assign pop      = StepTick & ~paused_q & (count_q != 3'd0);
   assign push     = ev_valid & (ev_dir != ref_dir) & (ev_dir != dir_reverse(ref_dir))
                     & (~full | pop);

   always_comb begin
      head_d    = pop  ? ptr_inc(head_q, QUEUE_DEPTH) : head_q;
      tail_d    = push ? ptr_inc(tail_q, QUEUE_DEPTH) : tail_q;
      heading_d = pop  ? q_mem[head_q] : heading_q;
      paused_d  = paused_q ^ press[BTN_CENTER];
      acc_d     = push;
      drop_d    = ev_valid & ~push;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         head_q    <= 2'd0;
         tail_q    <= 2'd0;
         count_q   <= 3'd0;
         heading_q <= DIR_RIGHT;
         paused_q  <= 1'b0;
         acc_q     <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         heading_q <= heading_d;
         paused_q  <= paused_d;
         acc_q     <= acc_d;
         drop_q    <= drop_d;
      end
   end

   // Queue storage holds data only; occupancy is tracked by the pointers and count.
   always_ff @(posedge Clock) begin
      if (push)
         q_mem[tail_q] <= ev_dir;
   end

   assign Heading     = heading_q;
   assign Paused      = paused_q;
   assign QueueCount  = count_q;
   assign DirAccepted = acc_q;
   assign DirDropped  = drop_q;

endmodule

// File: tb/tb_snake_direction_input.sv
// Scoreboard bench for snake_direction_input with DEBOUNCE_CYCLES=4.
// Honours SNAKE_DEBOUNCE_BYPASS_EN for the press latency.
module tb_snake_direction_input;

`ifdef SNAKE_DEBOUNCE_BYPASS_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 7;
`endif

   localparam logic [4:0] M_UP = 5'b00001;
   localparam logic [4:0] M_RT = 5'b00010;
   localparam logic [4:0] M_DN = 5'b00100;
   localparam logic [4:0] M_LT = 5'b01000;
   localparam logic [4:0] M_CT = 5'b10000;

   logic       clk = 1'b0;
   logic       Reset;
   logic [4:0] btn;
   logic       StepTick;
   logic [1:0] Heading;
   logic       Paused;
   logic [2:0] QueueCount;
   logic       DirAccepted;
   logic       DirDropped;

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      int kind;   // 0 accepted, 1 dropped
      int qc;
      int cyc;
   } exp_t;

   exp_t ev_q[$];
   int   hd_q[$];
   int   ps_q[$];

   snake_direction_input #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3),
      .QUEUE_DEPTH    (2)
   ) dut (
      .Clock       (clk),
      .Reset       (Reset),
      .ButtonLeft  (btn[3]),
      .ButtonRight (btn[1]),
      .ButtonUp    (btn[0]),
      .ButtonDown  (btn[2]),
      .ButtonCenter(btn[4]),
      .StepTick    (StepTick),
      .Heading     (Heading),
      .Paused      (Paused),
      .QueueCount  (QueueCount),
      .DirAccepted (DirAccepted),
      .DirDropped  (DirDropped)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] m, input int kind, input int qc);
      exp_t e;
      if (kind >= 0) begin
         e.kind = kind;
         e.qc   = qc;
         e.cyc  = cyc + LAT;
         ev_q.push_back(e);
      end
      btn = btn | m;
      cyc_wait(LAT + 3);
      btn = btn & ~m;
      cyc_wait(10);
   endtask

   task automatic step();
      StepTick = 1'b1;
      cyc_wait(1);
      StepTick = 1'b0;
      cyc_wait(2);
   endtask

   // Monitor: every pulse or state change must match the next queued expectation.
   initial begin
      exp_t e;
      int   prev_h;
      int   prev_p;
      prev_h = 1;
      prev_p = 0;
      forever begin
         @(negedge clk);
         if (Reset) begin
            prev_h = int'(Heading);
            prev_p = int'(Paused);
         end else begin
            if (DirAccepted || DirDropped) begin
               chk("ev_onehot", int'(DirAccepted & DirDropped), 0);
               if (ev_q.size() == 0) begin
                  chk("ev_unexpected", int'(DirAccepted) + 2 * int'(DirDropped), 0);
               end else begin
                  e = ev_q.pop_front();
                  chk("ev_kind", int'(DirDropped), e.kind);
                  chk("ev_queuecount", int'(QueueCount), e.qc);
                  chk("ev_cycle", cyc, e.cyc);
               end
            end
            if (int'(Heading) != prev_h) begin
               if (hd_q.size() == 0)
                  chk("heading_unexpected", int'(Heading), prev_h);
               else
                  chk("heading", int'(Heading), hd_q.pop_front());
            end
            if (int'(Paused) != prev_p) begin
               if (ps_q.size() == 0)
                  chk("paused_unexpected", int'(Paused), prev_p);
               else
                  chk("paused", int'(Paused), ps_q.pop_front());
            end
            prev_h = int'(Heading);
            prev_p = int'(Paused);
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      btn      = 5'b0;
      StepTick = 1'b0;
      Reset    = 1'b1;
      cyc_wait(3);
      chk("rst_heading", int'(Heading), 1);
      chk("rst_paused", int'(Paused), 0);
      chk("rst_queuecount", int'(QueueCount), 0);
      chk("rst_accepted", int'(DirAccepted), 0);
      chk("rst_dropped", int'(DirDropped), 0);
      Reset = 1'b0;
      cyc_wait(2);

      // Steps on an empty queue leave the heading alone.
      step(); step(); step();
      chk("idle_heading", int'(Heading), 1);
      chk("idle_queuecount", int'(QueueCount), 0);

      // Reversal and same-direction presses against Heading=RIGHT.
      press(M_LT, 1, 0);
      press(M_RT, 1, 0);
      chk("drop_queuecount", int'(QueueCount), 0);

`ifndef SNAKE_DEBOUNCE_BYPASS_EN
      for (int i = 0; i < 10; i++) begin
         btn[0] = (i % 2 == 0);
         cyc_wait(2);
      end
`endif
      e.kind = 0; e.qc = 1; e.cyc = cyc + LAT;
      ev_q.push_back(e);
      btn[0] = 1'b1;
      cyc_wait(LAT + 3);
      btn[0] = 1'b0;
      cyc_wait(10);
      hd_q.push_back(0);
      step();
      chk("bounce_queuecount", int'(QueueCount), 0);

      press(M_RT, 0, 1);
      hd_q.push_back(1);
      step();

      // Fill the queue, reject while full, then drain in order.
      press(M_UP, 0, 1);
      press(M_LT, 0, 2);
      press(M_DN, 1, 2);
      chk("full_queuecount", int'(QueueCount), 2);
      hd_q.push_back(0);
      step();
      hd_q.push_back(3);
      step();
      chk("drain_queuecount", int'(QueueCount), 0);

      // Full queue: a press landing on the pop cycle is accepted.
      press(M_UP, 0, 1);
      press(M_RT, 0, 2);
      e.kind = 0; e.qc = 2; e.cyc = cyc + LAT;
      ev_q.push_back(e);
      hd_q.push_back(0);
      btn[2] = 1'b1;
      cyc_wait(LAT - 1);
      StepTick = 1'b1;
      cyc_wait(1);
      StepTick = 1'b0;
      cyc_wait(3);
      btn[2] = 1'b0;
      cyc_wait(10);
      chk("pushpop_queuecount", int'(QueueCount), 2);
      hd_q.push_back(1);
      step();
      hd_q.push_back(2);
      step();

      // Heading=DOWN: Up wins over Left and is a reversal, so only a drop.
      press(M_UP | M_LT, 1, 0);
      chk("prio_queuecount", int'(QueueCount), 0);
      press(M_RT | M_LT, 0, 1);
      hd_q.push_back(1);
      step();

      // Pause blocks pops but not pushes.
      ps_q.push_back(1);
      press(M_CT, -1, 0);
      chk("pause_on", int'(Paused), 1);
      press(M_UP, 0, 1);
      step();
      chk("paused_heading", int'(Heading), 1);
      chk("paused_queuecount", int'(QueueCount), 1);
      ps_q.push_back(0);
      press(M_CT, -1, 0);
      hd_q.push_back(0);
      step();
      chk("unpause_queuecount", int'(QueueCount), 0);

      // Reset mid-debounce flushes the queue; a held button still presses afterwards.
      press(M_LT, 0, 1);
      chk("prereset_queuecount", int'(QueueCount), 1);
      btn[0] = 1'b1;
      cyc_wait(2);
      Reset = 1'b1;
      cyc_wait(2);
      chk("midrst_queuecount", int'(QueueCount), 0);
      chk("midrst_heading", int'(Heading), 1);
      Reset = 1'b0;
      e.kind = 0; e.qc = 1; e.cyc = cyc + LAT;
      ev_q.push_back(e);
      cyc_wait(LAT + 3);
      btn[0] = 1'b0;
      cyc_wait(10);
      hd_q.push_back(0);
      step();

      cyc_wait(5);
      chk("ev_left", ev_q.size(), 0);
      chk("heading_left", hd_q.size(), 0);
      chk("paused_left", ps_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
